// File: rtl/cp_corr_window.sv
// Sliding-window cyclic-prefix correlator: two-stage pipeline producing the running
// L-sample sums of r(n)*conj(r(n-N)) and the combined energy of both sample streams.
module cp_corr_window #(
  parameter int DW = 12,
  parameter int L  = 16,
  parameter int AW = 2*DW+1+$clog2(L)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] r_re,
  input  logic signed [DW-1:0] r_im,
  input  logic signed [DW-1:0] rd_re,
  input  logic signed [DW-1:0] rd_im,
  output logic                 out_valid,
  output logic signed [AW-1:0] gamma_re,
  output logic signed [AW-1:0] gamma_im,
  output logic        [AW-1:0] phi,
  output logic                 win_full
);
  localparam int PW = 2*DW+1;
  localparam int EW = PW+1;
  localparam int CW = $clog2(L+1);
  localparam logic [CW-1:0] CNT_FULL = CW'(L);

  typedef struct packed {
    logic signed [PW-1:0] p_re;
    logic signed [PW-1:0] p_im;
    logic        [PW-1:0] e;
  } trip_t;

  // vld_pipe[1]: stage-1 triple valid, vld_pipe[2]: sums updated (out_valid)
  logic [2:1]    vld_pipe;
  trip_t         s1, s1_c;
  trip_t         hist [L];
  logic [CW-1:0] cnt;

  // One extra bit of headroom keeps every intermediate exact before truncation.
  logic signed [EW-1:0] a, b, c, d, pr_w, pi_w, e_w;
  assign a    = EW'(r_re);
  assign b    = EW'(r_im);
  assign c    = EW'(rd_re);
  assign d    = EW'(rd_im);
  assign pr_w = a*c + b*d;
  assign pi_w = b*c - a*d;
  assign e_w  = a*a + b*b + c*c + d*d;

  always_comb begin
    s1_c      = '0;
    s1_c.p_re = pr_w[PW-1:0];
    s1_c.p_im = pi_w[PW-1:0];
    s1_c.e    = e_w[PW-1:0];
  end

  function automatic logic signed [AW-1:0] sx(input logic signed [PW-1:0] v);
    return AW'(v);
  endfunction

  // History is zero-filled, so subtracting the oldest slot during fill subtracts zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      gamma_re <= '0;
      gamma_im <= '0;
      phi      <= '0;
      cnt      <= '0;
      for (int i = 0; i < L; i++) hist[i] <= '0;
    end else if (clr) begin
      vld_pipe <= '0;
      s1       <= '0;
      gamma_re <= '0;
      gamma_im <= '0;
      phi      <= '0;
      cnt      <= '0;
      for (int i = 0; i < L; i++) hist[i] <= '0;
    end else begin
      vld_pipe[1] <= in_valid;
      vld_pipe[2] <= vld_pipe[1];
      if (in_valid) s1 <= s1_c;
      if (vld_pipe[1]) begin
        gamma_re <= gamma_re + sx(s1.p_re) - sx(hist[L-1].p_re);
        gamma_im <= gamma_im + sx(s1.p_im) - sx(hist[L-1].p_im);
        phi      <= phi + AW'(s1.e) - AW'(hist[L-1].e);
        hist[0]  <= s1;
        for (int i = 1; i < L; i++) hist[i] <= hist[i-1];
        if (cnt != CNT_FULL) cnt <= cnt + 1'b1;
      end
    end
  end

  assign out_valid = vld_pipe[2];
  assign win_full  = (cnt == CNT_FULL);

endmodule

// File: tb/tb_cp_corr_window.sv
// Scoreboard bench for cp_corr_window: a windowed-sum reference model queues the
// expected outputs per accepted pair; each scenario task pops and compares on out_valid.
module tb_cp_corr_window;
  localparam int DW = 12;
  localparam int L  = 16;
  localparam int AW = 2*DW+1+$clog2(L);
  localparam int VW = 3*AW+1;

  logic                 clk = 1'b0;
  logic                 rst, clr, in_valid;
  logic signed [DW-1:0] r_re, r_im, rd_re, rd_im;
  logic                 out_valid, win_full;
  logic signed [AW-1:0] gamma_re, gamma_im;
  logic        [AW-1:0] phi;

  always #5 clk = ~clk;

  cp_corr_window #(.DW(DW), .L(L)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .r_re(r_re), .r_im(r_im), .rd_re(rd_re), .rd_im(rd_im),
    .out_valid(out_valid), .gamma_re(gamma_re), .gamma_im(gamma_im),
    .phi(phi), .win_full(win_full)
  );

  wire [VW-1:0] obs = {gamma_re, gamma_im, phi, win_full};

  typedef struct { int pre; int pim; int e; } trip_t;
  trip_t        mh[$];
  logic [VW-1:0] q[$];
  int n_acc  = 0;
  int checks = 0;
  int fails  = 0;

  function automatic logic [VW-1:0] model_out();
    longint gr = 0, gi = 0, ph = 0;
    logic wf;
    foreach (mh[i]) begin
      gr += mh[i].pre;
      gi += mh[i].pim;
      ph += mh[i].e;
    end
    wf = (n_acc >= L);
    return {gr[AW-1:0], gi[AW-1:0], ph[AW-1:0], wf};
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic model_clear();
    q.delete();
    mh.delete();
    n_acc = 0;
  endtask

  // Drives one cycle and updates the model; comparisons are left to the caller.
  task automatic cyc(input bit v, input int a, input int b, input int c, input int d, input bit cl);
    trip_t t;
    in_valid = v; clr = cl;
    r_re = a[DW-1:0]; r_im = b[DW-1:0]; rd_re = c[DW-1:0]; rd_im = d[DW-1:0];
    if (cl) model_clear();
    else if (v) begin
      t.pre = a*c + b*d;
      t.pim = b*c - a*d;
      t.e   = a*a + b*b + c*c + d*d;
      mh.push_back(t);
      if (mh.size() > L) mh.delete(0);
      n_acc++;
      q.push_back(model_out());
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      r_re = DW'(rnd()); r_im = DW'(rnd()); rd_re = DW'(rnd()); rd_im = DW'(rnd());
      @(posedge clk); @(negedge clk);
      checks++;
      if ({out_valid, obs} !== '0) begin
        fails++; $display("FAIL reset_hold got ov=%b obs=%h want all zero", out_valid, obs);
      end
    end
    in_valid = 1'b0;
    rst = 1'b0;
    model_clear();
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if ({out_valid, obs} !== '0) begin
      fails++; $display("FAIL reset_release got ov=%b obs=%h want all zero", out_valid, obs);
    end
  endtask

  task automatic test_ramp();
    int k = 0;
    longint m, g, p;
    logic [VW-1:0] ev, cf;
    for (int i = 0; i < 22; i++) begin
      cyc(i < 20, 100, 0, 100, 0, 0);
      if (out_valid) begin
        k++;
        checks++;
        if (q.size() == 0) begin
          fails++; $display("FAIL ramp_spurious got out_valid=1 want 0");
        end else begin
          ev = q.pop_front();
          if (obs !== ev) begin fails++; $display("FAIL ramp_model k=%0d got %h want %h", k, obs, ev); end
        end
        m  = (k < 16) ? k : 16;
        g  = 10000 * m;
        p  = 20000 * m;
        cf = {g[AW-1:0], {AW{1'b0}}, p[AW-1:0], (k >= 16)};
        checks++;
        if (obs !== cf) begin fails++; $display("FAIL ramp_closed k=%0d got %h want %h", k, obs, cf); end
      end
    end
    checks++;
    if (k != 20) begin fails++; $display("FAIL ramp_count got %0d want 20", k); end
  endtask

  task automatic test_quad();
    logic [VW-1:0] want, ev;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 50, 50, 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL quad_early got out_valid=%b want 0", out_valid); end
    cyc(0, 0, 0, 0, 0, 0);
    want = {AW'(0), AW'(2500), AW'(5000), 1'b0};
    checks++;
    if (out_valid !== 1'b1 || obs !== want) begin
      fails++; $display("FAIL quad_value got ov=%b obs=%h want ov=1 obs=%h", out_valid, obs, want);
    end
    if (q.size() != 0) ev = q.pop_front();
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || obs !== want) begin
      fails++; $display("FAIL quad_hold got ov=%b obs=%h want ov=0 obs=%h", out_valid, obs, want);
    end
  endtask

  task automatic test_extremes();
    logic [VW-1:0] ev, want;
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(i < 18, -2048, -2048, -2048, -2048, 0);
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          fails++; $display("FAIL ext_spurious got out_valid=1 want 0");
        end else begin
          ev = q.pop_front();
          if (obs !== ev) begin fails++; $display("FAIL ext_model i=%0d got %h want %h", i, obs, ev); end
        end
      end
    end
    want = {AW'(134217728), AW'(0), AW'(268435456), 1'b1};
    checks++;
    if (obs !== want) begin fails++; $display("FAIL ext_final got %h want %h", obs, want); end
  endtask

  task automatic test_bubbles();
    int acc = 0, ovs = 0;
    bit v;
    logic [VW-1:0] ev, last;
    cyc(0, 0, 0, 0, 0, 1);
    last = obs;
    for (int i = 0; i < 62; i++) begin
      v = (i < 60) && (i % 3 == 0);
      if (v) acc++;
      cyc(v, rnd(), rnd(), rnd(), rnd(), 0);
      checks++;
      if (out_valid) begin
        ovs++;
        if (q.size() == 0) begin
          fails++; $display("FAIL bub_spurious got out_valid=1 want 0");
        end else begin
          ev = q.pop_front();
          if (obs !== ev) begin fails++; $display("FAIL bub_model i=%0d got %h want %h", i, obs, ev); end
        end
      end else if (obs !== last) begin
        fails++; $display("FAIL bub_hold i=%0d got %h want %h", i, obs, last);
      end
      last = obs;
    end
    checks++;
    if (ovs != acc) begin fails++; $display("FAIL bub_count got %0d want %0d", ovs, acc); end
  endtask

  task automatic test_flush();
    logic [VW-1:0] ev, want;
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 18; i++) begin
      cyc(1, rnd(), rnd(), rnd(), rnd(), 0);
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          fails++; $display("FAIL flush_spurious got out_valid=1 want 0");
        end else begin
          ev = q.pop_front();
          if (obs !== ev) begin fails++; $display("FAIL flush_model i=%0d got %h want %h", i, obs, ev); end
        end
      end
    end
    cyc(1, rnd(), rnd(), rnd(), rnd(), 1);
    checks++;
    if ({out_valid, obs} !== '0) begin
      fails++; $display("FAIL flush_clear got ov=%b obs=%h want all zero", out_valid, obs);
    end
    cyc(1, 10, 20, 30, 40, 0);
    checks++;
    if ({out_valid, obs} !== '0) begin
      fails++; $display("FAIL flush_drop got ov=%b obs=%h want all zero", out_valid, obs);
    end
    cyc(0, 0, 0, 0, 0, 0);
    want = {AW'(1100), AW'(200), AW'(3000), 1'b0};
    checks++;
    if (out_valid !== 1'b1 || obs !== want) begin
      fails++; $display("FAIL flush_first got ov=%b obs=%h want ov=1 obs=%h", out_valid, obs, want);
    end
    if (q.size() != 0) ev = q.pop_front();
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] ev;
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 62; i++) begin
      cyc((i < 60) && ($urandom_range(0, 3) != 0), rnd(), rnd(), rnd(), rnd(), 0);
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          fails++; $display("FAIL b2b_spurious got out_valid=1 want 0");
        end else begin
          ev = q.pop_front();
          if (obs !== ev) begin fails++; $display("FAIL b2b_model i=%0d got %h want %h", i, obs, ev); end
        end
      end
    end
    checks++;
    if (q.size() != 0) begin fails++; $display("FAIL b2b_drain got %0d pending want 0", q.size()); end
  endtask

  task automatic test_midreset();
    logic [VW-1:0] ev;
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, rnd(), rnd(), rnd(), rnd(), 0);
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          fails++; $display("FAIL mrst_spurious got out_valid=1 want 0");
        end else begin
          ev = q.pop_front();
          if (obs !== ev) begin fails++; $display("FAIL mrst_model i=%0d got %h want %h", i, obs, ev); end
        end
      end
    end
    rst = 1'b1;
    in_valid = 1'b1;
    model_clear();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({out_valid, obs} !== '0) begin
        fails++; $display("FAIL mrst_abort got ov=%b obs=%h want all zero", out_valid, obs);
      end
    end
    in_valid = 1'b0;
    rst = 1'b0;
    cyc(1, -7, 3, 5, -9, 0);
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mrst_early got out_valid=%b want 0", out_valid); end
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || q.size() == 0) begin
      fails++; $display("FAIL mrst_first got out_valid=%b want 1", out_valid);
    end else begin
      ev = q.pop_front();
      if (obs !== ev) begin fails++; $display("FAIL mrst_first got %h want %h", obs, ev); end
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
    r_re = '0; r_im = '0; rd_re = '0; rd_im = '0;
    @(negedge clk);
    test_reset();
    test_ramp();
    test_quad();
    test_extremes();
    test_bubbles();
    test_flush();
    test_back_to_back();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
